// File: rtl/div_seq_pkg.sv
// Shared constants for the E-stage iterative divider: FSM encodings and default widths.
package div_seq_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 5;

    typedef logic [1:0] div_state_t;

    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_BUSY = 2'd1;
    localparam div_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/div_seq_if.sv
// E-stage <-> divider handshake: operands and control in, stall/done and HI/LO results out.
interface div_seq_if #(
    parameter int unsigned WIDTH = 32
);

    logic             div_validE;
    logic             signedE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             annulE;
    logic             div_stallE;
    logic             div_doneE;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output div_validE, signedE, srcaE, srcbE, annulE,
        input  div_stallE, div_doneE, hi_o, lo_o
    );

    modport slave (
        input  div_validE, signedE, srcaE, srcbE, annulE,
        output div_stallE, div_doneE, hi_o, lo_o
    );

endinterface

// File: rtl/div_seq_step.sv
// One combinational radix-2 restoring step: shift {rem,quo} left, subtract divisor if it fits.
module div_seq_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        // No borrow out of the WIDTH+1 bit subtract means shifted >= divisor.
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequencer for the E-stage iterative divider: DIV/DIVU as a radix-2 restoring divide,
// one quotient bit per cycle, stalling F/D/E while it runs.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input logic   clk,
    input logic   rst,
    div_seq_if.slave bus
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             issue;
    logic             last_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    assign issue     = (state_q == ST_IDLE) && bus.div_validE && !bus.annulE;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
    assign a_mag     = (bus.signedE && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
    assign b_mag     = (bus.signedE && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

    div_seq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    rem_d     = '0;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    neg_quo_d = bus.signedE && (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
                    neg_rem_d = bus.signedE && bus.srcaE[WIDTH-1];
                    cnt_d     = '0;
                    if (bus.srcbE == '0) begin
                        // Divide by zero skips the iteration: raw dividend and all-ones quotient.
                        state_d = ST_DONE;
                        hi_d    = bus.srcaE;
                        lo_d    = '1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.annulE) begin
                    state_d = ST_IDLE;
                end else if (last_step) begin
                    // Results are registered here so they hold after DONE until the next divide.
                    state_d = ST_DONE;
                    hi_d    = neg_rem_q ? -rem_nx : rem_nx;
                    lo_d    = neg_quo_q ? -quo_nx : quo_nx;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Mealy stall so the hazard unit holds E in the issue cycle itself.
    assign bus.div_stallE = issue || (state_q == ST_BUSY);
    assign bus.div_doneE  = (state_q == ST_DONE) && !bus.annulE;
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: expected HI/LO pushed at issue, popped and compared on done.
module tb_div_seq;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    logic clk = 1'b0;
    logic rst;

    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(
        .WIDTH (W),
        .CNT_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    res_t        sb[$];
    int unsigned checks = 0;
    int unsigned passed = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        bus.div_validE = 1'b0;
        bus.annulE     = 1'b0;
        #1;
        check({tag, "/idle_done"}, 32'(bus.div_doneE), 32'd0);
    endtask

    // Issues one divide, holds it in E while stalled, and checks the done cycle.
    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] hi,
                           input logic [W-1:0] lo, input int exp_stall);
        res_t exp;
        int   n;
        bit   got;
        sb.push_back({hi, lo});
        @(negedge clk);
        bus.div_validE = 1'b1;
        bus.signedE    = sgn;
        bus.srcaE      = a;
        bus.srcbE      = b;
        #1;
        check({tag, "/done_at_issue"}, 32'(bus.div_doneE), 32'd0);
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.div_doneE) begin
                got = 1'b1;
                break;
            end
            if (bus.div_stallE) n++;
            @(negedge clk);
            #1;
        end
        check({tag, "/done_seen"}, 32'(got), 32'd1);
        check({tag, "/stall_cycles"}, 32'(n), 32'(exp_stall));
        check({tag, "/stall_in_done"}, 32'(bus.div_stallE), 32'd0);
        if (sb.size() == 0) begin
            check({tag, "/scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            check({tag, "/hi"}, bus.hi_o, exp.hi);
            check({tag, "/lo"}, bus.lo_o, exp.lo);
        end
    endtask

    initial begin
        bit seen;

        rst            = 1'b1;
        bus.div_validE = 1'b0;
        bus.signedE    = 1'b0;
        bus.srcaE      = '0;
        bus.srcbE      = '0;
        bus.annulE     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset/stall", 32'(bus.div_stallE), 32'd0);
        check("reset/done", 32'(bus.div_doneE), 32'd0);
        check("reset/hi", bus.hi_o, 32'd0);
        check("reset/lo", bus.lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        idle_cycle("divu_100_7");
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        idle_cycle("div_m7_2");
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        idle_cycle("div_7_m2");
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        idle_cycle("div_min_m1");
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 33);
        idle_cycle("divu_max_1");
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
        idle_cycle("divu_5_0");
        check("hold/hi", bus.hi_o, 32'd5);
        check("hold/lo", bus.lo_o, 32'hFFFF_FFFF);

        // Annul on the tenth BUSY cycle.
        @(negedge clk);
        bus.div_validE = 1'b1;
        bus.signedE    = 1'b0;
        bus.srcaE      = 32'd1000;
        bus.srcbE      = 32'd3;
        #1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 10) begin
                bus.annulE     = 1'b1;
                bus.div_validE = 1'b0;
            end
            #1;
        end
        check("annul/stall_in_annul_cycle", 32'(bus.div_stallE), 32'd1);
        check("annul/done_in_annul_cycle", 32'(bus.div_doneE), 32'd0);
        @(negedge clk);
        bus.annulE = 1'b0;
        #1;
        check("annul/stall_after", 32'(bus.div_stallE), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.div_doneE || bus.div_stallE) seen = 1'b1;
            @(negedge clk);
            #1;
        end
        check("annul/no_done_or_stall", 32'(seen), 32'd0);
        check("annul/hi_held", bus.hi_o, 32'd5);

        // Back-to-back: second divide issues in the cycle right after the first DONE.
        run_div("b2b_9_4", 1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 33);
        run_div("b2b_9_2", 1'b0, 32'd9, 32'd2, 32'd1, 32'd4, 33);
        idle_cycle("b2b_end");
        check("b2b/scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
